// File: rtl/fetch_queue.sv
// fetch_queue: small in-order queue between fetch and decode.
// Flush empties it and opens a short window that drops late fetch beats.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   flush, stall                    redirect from execute, hold from decode
//   in_valid/in_pc/in_instr         fetch beat; in_ready accepts it
//   out_valid/out_pc/out_instr      head entry for decode (NOP when empty)
//   count                           occupied entries
//   kill_active                     post-flush discard window open
module fetch_queue #(
    parameter int          XLEN        = 32,
    parameter int          DEPTH       = 2,
    parameter int          KILL_CYCLES = 1,
    parameter logic [31:0] NOP         = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       stall,
    input  logic                       in_valid,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [31:0]                in_instr,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [XLEN-1:0]            out_pc,
    output logic [31:0]                out_instr,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       kill_active
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [XLEN-1:0] pc_mem_q    [DEPTH];
    logic [31:0]     instr_mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [2:0]    kill_q, kill_d;

    logic store;
    logic pop;

    // Handshake and head presentation
    always_comb begin
        kill_active = (kill_q != 3'd0);
        // Ready while killing so the fetch side drains
        // its stale beats instead of stalling on them.
        in_ready    = (count_q < CW'(DEPTH)) | kill_active;
        out_valid   = (count_q != '0);
        store       = in_valid & in_ready
                    & ~flush & ~kill_active;
        pop         = out_valid & ~stall & ~flush;
        out_pc      = out_valid ? pc_mem_q[rd_ptr_q] : '0;
        out_instr   = out_valid ? instr_mem_q[rd_ptr_q] : NOP;
        count       = count_q;
    end

    // Next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        kill_d   = kill_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            kill_d   = 3'(KILL_CYCLES);
        end else begin
            if (store) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
            unique case ({store, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (kill_active) kill_d = kill_q - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            kill_q   <= 3'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            kill_q   <= kill_d;
        end
    end

    // Storage is not reset; it is masked while count is zero.
    always_ff @(posedge clk) begin
        if (store && !rst) begin
            pc_mem_q[wr_ptr_q]    <= in_pc;
            instr_mem_q[wr_ptr_q] <= in_instr;
        end
    end

endmodule
